// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep left/right holding buffer feeding a per-frame shadow
// register that is shifted out MSB first with the standard one-bit delay after lrck.
module i2s_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int SLOT_WIDTH = 16
) (
   input  logic                  sck,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] ldata,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic                  lrck,
   output logic                  sdata,
   output logic                  underrun
);

   // state | meaning
   // IDLE  | not transmitting, lrck=1, sdata=0, waiting for en
   // RUN   | frame in progress, cnt walks 0..2*SLOT_WIDTH-1
   // TAIL  | single cycle carrying the last right-slot bit, then IDLE

   localparam int FW = 2 * SLOT_WIDTH;
   localparam int CW = $clog2(FW);
   localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
   localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_TAIL
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    lrck_q, lrck_d;
   logic                    sdata_q, sdata_d;
   logic                    under_q, under_d;
   logic                    full_q, full_d;
   logic [DATA_WIDTH-1:0]   bufl_q, bufl_d;
   logic [DATA_WIDTH-1:0]   bufr_q, bufr_d;
   logic [FW-1:0]           shift_q, shift_d;

   logic                    load;
   logic                    accept;
   logic [CW-1:0]           cnt_inc;
   logic [SLOT_WIDTH-1:0]   lslot;
   logic [SLOT_WIDTH-1:0]   rslot;

   // Samples sit left-justified in their slot; the pad bits below them are zero.
   assign lslot   = SLOT_WIDTH'(bufl_q) << (SLOT_WIDTH - DATA_WIDTH);
   assign rslot   = SLOT_WIDTH'(bufr_q) << (SLOT_WIDTH - DATA_WIDTH);
   assign cnt_inc = cnt_q + CW'(1);
   assign accept  = in_vld && !full_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lrck_d  = lrck_q;
      sdata_d = sdata_q;
      under_d = 1'b0;
      full_d  = full_q;
      bufl_d  = bufl_q;
      bufr_d  = bufr_q;
      shift_d = shift_q;
      load    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            lrck_d  = 1'b1;
            sdata_d = 1'b0;
            if (en) begin
               state_d = S_RUN;
               load    = 1'b1;
               lrck_d  = 1'b0;
            end
         end
         S_RUN: begin
            // The shift MSB always holds the frame bit due one cycle after its slot position.
            sdata_d = shift_q[FW-1];
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (en) begin
                  load   = 1'b1;
                  lrck_d = 1'b0;
               end else begin
                  state_d = S_TAIL;
                  lrck_d  = 1'b1;
               end
            end else begin
               cnt_d   = cnt_inc;
               lrck_d  = (cnt_inc >= CNT_SLOT);
               shift_d = shift_q << 1;
            end
         end
         S_TAIL: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            lrck_d  = 1'b1;
            sdata_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            lrck_d  = 1'b1;
            sdata_d = 1'b0;
         end
      endcase

      if (load) begin
         under_d = !full_q;
         shift_d = full_q ? {lslot, rslot} : '0;
         full_d  = 1'b0;
      end

      // A full buffer keeps in_rdy low through the load cycle, so accept never races the load.
      if (accept) begin
         bufl_d = ldata;
         bufr_d = rdata;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lrck_q  <= 1'b1;
         sdata_q <= 1'b0;
         under_q <= 1'b0;
         full_q  <= 1'b0;
         bufl_q  <= '0;
         bufr_q  <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lrck_q  <= lrck_d;
         sdata_q <= sdata_d;
         under_q <= under_d;
         full_q  <= full_d;
         bufl_q  <= bufl_d;
         bufr_q  <= bufr_d;
         shift_q <= shift_d;
      end
   end

   assign in_rdy   = ~full_q;
   assign lrck     = lrck_q;
   assign sdata    = sdata_q;
   assign underrun = under_q;

endmodule
